flap_scheduler: RTL and testbench
=================================

# flap_scheduler

Arbitrates flap requests from up to NREQ player buttons and issues at most one flap command per game tick to the bird physics datapath. Each requester gets release-edge detection and a sticky pending flag. A round-robin arbiter with a post-grant cooldown drains the pending flags. The block sits between the raw KEY inputs and the bird position/velocity logic, and replaces per-button point/flap buffers.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- COOLDOWN, 3, idle cycles enforced after each flap pulse (0..255)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  game frame strobe, one cycle wide
- enable  in  1  game in PLAY state; low flushes requests
- press  in  NREQ  raw button levels, 1 = held
- flap  out  1  one-cycle flap command
- flap_id  out  $clog2(NREQ)  requester served by current or last flap
- pending  out  NREQ  sticky request flags
- busy  out  1  high in GRANT or COOL
- dropped  out  1  one-cycle pulse when an event hits an already-set pending bit

## Operation
Per-requester edge detection:
- press_s[i] is press[i], or the 2-flop synchronized version (see Configuration).
- prev[i] <= press_s[i] every cycle.
- event[i] = prev[i] & ~press_s[i], i.e. release, as in the existing button convention.

Pending flags:
- event[i] sets pending[i].
- If pending[i] is already 1 and not being cleared this edge, dropped = 1 for that cycle. Events coalesce; no counting.
- enable = 0: all pending bits are cleared at every edge and events are ignored.

FSM states: IDLE, GRANT, COOL.
- IDLE -> GRANT when tick & enable & |pending. The winner is the first set bit searching upward from rr_ptr+1 mod NREQ.
  - At that edge: flap_id <= winner, rr_ptr <= winner, pending[winner] cleared.
  - A same-edge event on the winner wins: pending stays 1, and dropped is not asserted.
- GRANT: flap = 1 for exactly this cycle. Next state is COOL with cnt <= COOLDOWN-1, or IDLE if COOLDOWN = 0.
- COOL: cnt decrements each cycle; go to IDLE when cnt = 0.
- A tick arriving in GRANT or COOL is ignored; requests stay pending for a later tick.
- GRANT and COOL run to completion regardless of enable.

Other outputs:
- busy = (state != IDLE).
- cnt width is 8 bits, with no wrap: it is only loaded from GRANT.

## Timing
Reset (rst low, asynchronous):
- state = IDLE, flap = 0, flap_id = 0, pending = 0, busy = 0, dropped = 0.
- prev = 0, rr_ptr = NREQ-1 (requester 0 wins first), cnt = 0.
- Sync flops are cleared to 0.
- Reset mid-GRANT or mid-COOL aborts immediately and no flap is emitted.

Latency without sync:
- Release seen at edge k sets pending at edge k.
- A tick at edge k+n (n >= 1) enters GRANT.
- flap is high during the cycle after that edge, so tick-to-flap is 1 cycle.

Latency with sync: release-to-pending grows by 2 cycles.

Flap spacing:
- Minimum spacing between flap pulses is COOLDOWN+1 cycles from GRANT to IDLE, plus waiting for the next tick.
- Event and grant on the same edge for different requesters are independent.

## Configuration
- FLAP_SYNC_EN defined: each press bit passes through two flops before edge detection. Adds 2 cycles of latency and is required for asynchronous KEY inputs.
- FLAP_SYNC_EN undefined: press_s = press directly. Inputs must already be synchronous to clk.

## Test plan
Defaults: NREQ = 4, COOLDOWN = 3, FLAP_SYNC_EN undefined.
- Reset, then hold press = 0000 for 5 cycles -> pending = 0000, no flap, no dropped. Confirms no spurious event after reset.
- press[2] high 3 cycles then low; enable = 1; tick 2 cycles later -> pending = 0100, then one cycle later flap = 1, flap_id = 2, pending = 0000, busy for 4 cycles.
- Release requesters 0, 1, 3 simultaneously; a tick every 6 cycles -> flaps in order flap_id 0, 1, 3, pending drains 1011 -> 1010 -> 1000 -> 0000.
- Tick during COOL with pending = 0001 -> no flap; next tick after busy falls -> flap_id = 0.
- Release requester 1 twice before any tick -> dropped pulses once, pending[1] = 1, exactly one flap.
- enable = 0 with pending = 1111, plus tick -> pending = 0000 next cycle, no flap. Assert rst mid-COOL -> busy = 0 immediately.

Source files
------------

// File: rtl/flap_scheduler.sv
// Purpose: picks at most one released button per game tick and issues a one-cycle flap to the bird physics.
// Latency: release-to-pending 0 cycles (2 with FLAP_SYNC_EN), tick-to-flap 1 cycle, then COOLDOWN idle cycles.
// Backpressure: none downstream; requests coalesce in sticky pending flags, and overflow shows up as a dropped pulse.
// Optional feature macro: FLAP_SYNC_EN adds a 2-flop synchronizer on each press bit.
module flap_scheduler #(
  parameter int NREQ     = 4,
  parameter int COOLDOWN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    enable,
  input  logic [NREQ-1:0]         press,
  output logic                    flap,
  output logic [$clog2(NREQ)-1:0] flap_id,
  output logic [NREQ-1:0]         pending,
  output logic                    busy,
  output logic                    dropped
);

  localparam int IDW = $clog2(NREQ);
  // The counter only holds the remaining COOL cycles, so it is loaded with COOLDOWN-1.
  localparam logic [7:0] CNT_LOAD = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [NREQ-1:0] press_s;
  logic [NREQ-1:0] prev;
  logic [NREQ-1:0] ev;
  logic [NREQ-1:0] clr_mask;
  logic [NREQ-1:0] pending_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            found;
  logic            grant_go;

`ifdef FLAP_SYNC_EN
  logic [NREQ-1:0] sync1, sync2;

  // Two-flop synchronizer for KEY inputs that are asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= press;
      sync2 <= sync1;
    end
  end

  assign press_s = sync2;
`else
  assign press_s = press;
`endif

  // A button event is its release, matching the existing button convention.
  assign ev = prev & ~press_s;

  // Round-robin search: the first pending bit upward from rr_ptr+1, wrapping at NREQ.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && pending[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // A grant is only taken from IDLE; ticks arriving while busy are ignored.
  assign grant_go = (state == IDLE) && tick && enable && (|pending);

  // Pending update: the winner is cleared, new events set their bits, and a low enable flushes everything.
  // A same-edge event on the winner re-sets its bit, so the request is not lost and is not a drop.
  always_comb begin
    clr_mask = '0;
    if (grant_go) begin
      clr_mask[winner] = 1'b1;
    end
    pending_nxt = '0;
    dropped     = 1'b0;
    if (enable) begin
      pending_nxt = (pending & ~clr_mask) | ev;
      dropped     = |(ev & pending & ~clr_mask);
    end
  end

  // Next-state logic for the IDLE -> GRANT -> COOL -> IDLE sequence.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_go) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (COOLDOWN == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = COOL;
          cnt_nxt   = CNT_LOAD;
        end
      end
      COOL: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter, and request registers. Reset aborts any flap that is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      prev    <= '0;
      pending <= '0;
      rr_ptr  <= IDW'(NREQ - 1);
      flap_id <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      prev    <= press_s;
      pending <= pending_nxt;
      if (grant_go) begin
        rr_ptr  <= winner;
        flap_id <= winner;
      end
    end
  end

  assign flap = (state == GRANT);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_flap_scheduler.sv
// Directed bench for flap_scheduler with the default configuration (NREQ=4, COOLDOWN=3, no sync).
// Inputs are driven 1 time unit after the rising edge; registered outputs are sampled there too.
// Combinational outputs such as dropped are sampled one more time unit later, after the inputs settle.
module tb_flap_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] press = 4'b0000;
  logic       flap;
  logic [1:0] flap_id;
  logic [3:0] pending;
  logic       busy;
  logic       dropped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flap_scheduler #(.NREQ(4), .COOLDOWN(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .enable  (enable),
    .press   (press),
    .flap    (flap),
    .flap_id (flap_id),
    .pending (pending),
    .busy    (busy),
    .dropped (dropped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    tick   = 1'b0;
    enable = 1'b0;
    press  = 4'b0000;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  int n_busy;
  int n_flap;
  int n_drop;

  initial begin
    // Reset state.
    do_reset();
    rst = 1'b0;
    #1;
    check("rst_flap", flap, 0);
    check("rst_id", flap_id, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    cyc();
    rst = 1'b1;

    // No spurious event after reset with press held low.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_pending", pending, 0);
      check("idle_flap", flap, 0);
      #1;
      check("idle_dropped", dropped, 0);
    end

    // Single request on requester 2.
    press = 4'b0100;
    cyc();
    cyc();
    cyc();
    press = 4'b0000;
    cyc();
    check("r2_pending", pending, 4'b0100);
    check("r2_noflap", flap, 0);
    cyc();
    check("r2_pending_hold", pending, 4'b0100);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("r2_flap", flap, 1);
    check("r2_id", flap_id, 2);
    check("r2_pending_clr", pending, 0);
    n_busy = 0;
    n_flap = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) n_busy++;
      if (flap) n_flap++;
      cyc();
    end
    check("r2_busy_cycles", n_busy, 4);
    check("r2_flap_count", n_flap, 1);

    // Round-robin drain of requesters 0, 1, 3 from a fresh pointer.
    do_reset();
    enable = 1'b1;
    cyc();
    press = 4'b1011;
    cyc();
    press = 4'b0000;
    cyc();
    check("rr_pending0", pending, 4'b1011);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("rr_flap_a", flap, 1);
    check("rr_id_a", flap_id, 0);
    check("rr_pend_a", pending, 4'b1010);
    for (int i = 0; i < 5; i++) cyc();
    check("rr_idle_a", busy, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("rr_flap_b", flap, 1);
    check("rr_id_b", flap_id, 1);
    check("rr_pend_b", pending, 4'b1000);
    for (int i = 0; i < 5; i++) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("rr_flap_c", flap, 1);
    check("rr_id_c", flap_id, 3);
    check("rr_pend_c", pending, 4'b0000);
    for (int i = 0; i < 5; i++) cyc();

    // Tick during COOL is ignored; request 0 is served at the next tick after busy falls.
    press = 4'b0010;
    cyc();
    press = 4'b0000;
    cyc();
    check("cool_pend1", pending, 4'b0010);
    press = 4'b0001;
    tick  = 1'b1;
    cyc();
    check("cool_flap1", flap, 1);
    check("cool_id1", flap_id, 1);
    press = 4'b0000;
    tick  = 1'b0;
    cyc();
    check("cool_pend0", pending, 4'b0001);
    check("cool_busy", busy, 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("cool_tick_noflap", flap, 0);
    check("cool_tick_pend", pending, 4'b0001);
    cyc();
    cyc();
    check("cool_done_busy", busy, 0);
    check("cool_done_noflap", flap, 0);
    check("cool_done_pend", pending, 4'b0001);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("cool_flap0", flap, 1);
    check("cool_id0", flap_id, 0);
    check("cool_pend_clr", pending, 0);
    for (int i = 0; i < 5; i++) cyc();

    // Double release of requester 1 coalesces with one dropped pulse and one flap.
    n_drop = 0;
    press = 4'b0010;
    cyc();
    press = 4'b0000;
    #1;
    if (dropped) n_drop++;
    cyc();
    check("dbl_pend_a", pending, 4'b0010);
    press = 4'b0010;
    #1;
    if (dropped) n_drop++;
    cyc();
    press = 4'b0000;
    #1;
    check("dbl_drop_pulse", dropped, 1);
    if (dropped) n_drop++;
    cyc();
    #1;
    if (dropped) n_drop++;
    check("dbl_drop_count", n_drop, 1);
    check("dbl_pend_b", pending, 4'b0010);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_flap = 0;
    check("dbl_id", flap_id, 1);
    for (int i = 0; i < 10; i++) begin
      if (flap) n_flap++;
      cyc();
    end
    check("dbl_flap_count", n_flap, 1);
    check("dbl_pend_clr", pending, 0);

    // enable low flushes all pending requests and blocks the tick.
    press = 4'b1111;
    cyc();
    press = 4'b0000;
    cyc();
    check("en_pend_full", pending, 4'b1111);
    enable = 1'b0;
    tick   = 1'b1;
    cyc();
    tick = 1'b0;
    check("en_pend_flush", pending, 0);
    check("en_noflap", flap, 0);
    check("en_nobusy", busy, 0);
    enable = 1'b1;

    // Asynchronous reset in the middle of COOL aborts at once.
    press = 4'b0100;
    cyc();
    press = 4'b0000;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("ar_flap", flap, 1);
    cyc();
    check("ar_busy_cool", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy_now", busy, 0);
    check("ar_flap_now", flap, 0);
    check("ar_id_now", flap_id, 0);
    cyc();
    rst = 1'b1;

    // Same-edge event on the winner keeps its pending bit and is not a drop.
    enable = 1'b1;
    press  = 4'b0001;
    cyc();
    press = 4'b0000;
    cyc();
    check("se_pend", pending, 4'b0001);
    press = 4'b0001;
    cyc();
    press = 4'b0000;
    tick  = 1'b1;
    #1;
    check("se_nodrop", dropped, 0);
    cyc();
    tick = 1'b0;
    check("se_flap", flap, 1);
    check("se_id", flap_id, 0);
    check("se_pend_kept", pending, 4'b0001);
    for (int i = 0; i < 5; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
